// File: rtl/counter_header_checker_if.sv
// AXI-Stream beat bundle shared by the input and output sides of the header checker.
interface counter_header_checker_if #(
    parameter int DW = 512
);
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tvalid;
    logic            tready;
    logic            tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/counter_header_checker.sv
// Strips the counter header beat from each AXI-Stream packet and checks that
// header sequence numbers increment by one, keeping error/packet/empty counts.
module counter_header_checker #(
    parameter int DW = 512
) (
    input  logic                            clk,
    input  logic                            resetn,
    counter_header_checker_if.slave         axis_in,
    counter_header_checker_if.master        axis_out,
    output logic                            SEQ_ERR,
    output logic [15:0]                     SEQ_ERR_CNT,
    output logic [31:0]                     PKT_CNT,
    output logic [15:0]                     EMPTY_CNT
);
    typedef enum logic {HDR, PAY} state_e;

    state_e            state_q, state_d;
    logic [31:0]       exp_q, exp_d;
    logic              synced_q, synced_d;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [15:0]       empty_cnt_q, empty_cnt_d;
    logic              seq_err_q, seq_err_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic [DW/8-1:0]   out_keep_q, out_keep_d;
    logic              out_last_q, out_last_d;

    logic              in_ready;
    logic              in_fire;
    logic [31:0]       seq;

    // Headers are always accepted so a stalled output never blocks the
    // sequence check; the output register is simply left alone in HDR.
    assign in_ready = resetn && ((state_q == HDR) || !out_valid_q || axis_out.tready);
    assign in_fire  = axis_in.tvalid && in_ready;
    assign seq      = axis_in.tdata[31:0];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        exp_d       = exp_q;
        synced_d    = synced_q;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;
        empty_cnt_d = empty_cnt_q;
        seq_err_d   = 1'b0;
        out_valid_d = out_valid_q && !axis_out.tready;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;

        case (state_q)
            HDR: begin
                if (in_fire) begin
                    exp_d     = seq + 32'd1;
                    synced_d  = 1'b1;
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                    if (synced_q && (seq != exp_q)) begin
                        seq_err_d = 1'b1;
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (axis_in.tlast) begin
                        if (empty_cnt_q != 16'hFFFF) empty_cnt_d = empty_cnt_q + 16'd1;
                    end else begin
                        state_d = PAY;
                    end
                end
            end
            PAY: begin
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    out_data_d  = axis_in.tdata;
                    out_keep_d  = axis_in.tkeep;
                    out_last_d  = axis_in.tlast;
                    if (axis_in.tlast) state_d = HDR;
                end
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= HDR;
            exp_q       <= '0;
            synced_q    <= 1'b0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            empty_cnt_q <= '0;
            seq_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            synced_q    <= synced_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            empty_cnt_q <= empty_cnt_d;
            seq_err_q   <= seq_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    assign axis_in.tready  = in_ready;
    assign axis_out.tvalid = out_valid_q;
    assign axis_out.tdata  = out_data_q;
    assign axis_out.tkeep  = out_keep_q;
    assign axis_out.tlast  = out_last_q;
    assign SEQ_ERR         = seq_err_q;
    assign SEQ_ERR_CNT     = err_cnt_q;
    assign PKT_CNT         = pkt_cnt_q;
    assign EMPTY_CNT       = empty_cnt_q;
endmodule

// File: tb/tb_counter_header_checker.sv
// Directed bench for counter_header_checker: a packet-level model predicts the
// payload stream and counters, and a per-cycle compare process checks the DUT.
module tb_counter_header_checker;
    localparam int DW = 128;
    localparam int KW = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    counter_header_checker_if #(.DW(DW)) in_if ();
    counter_header_checker_if #(.DW(DW)) out_if ();

    logic        seq_err;
    logic [15:0] err_cnt;
    logic [31:0] pkt_cnt;
    logic [15:0] empty_cnt;

    counter_header_checker #(.DW(DW)) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .axis_in     (in_if),
        .axis_out    (out_if),
        .SEQ_ERR     (seq_err),
        .SEQ_ERR_CNT (err_cnt),
        .PKT_CNT     (pkt_cnt),
        .EMPTY_CNT   (empty_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: p_* is updated when a beat is accepted, m_* is what the DUT shows after the edge.
    beat_t       exp_beats[$];
    logic [31:0] p_exp = '0;
    bit          p_synced = 0;
    bit          p_err = 0;
    logic [15:0] p_errcnt = '0, p_empty = '0;
    logic [31:0] p_pkt = '0;
    bit          m_err = 0;
    logic [15:0] m_errcnt = '0, m_empty = '0;
    logic [31:0] m_pkt = '0;

    bit rand_ready = 0;
    int beats_out = 0, tlast_seen = 0, err_pulses = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_accept(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input bit hdr);
        beat_t b;
        if (hdr) begin
            if (p_synced && d[31:0] != p_exp) begin
                p_err = 1;
                if (p_errcnt != 16'hFFFF) p_errcnt++;
            end
            p_exp    = d[31:0] + 32'd1;
            p_synced = 1;
            p_pkt++;
            if (l && p_empty != 16'hFFFF) p_empty++;
        end else begin
            b.data = d; b.keep = k; b.last = l;
            exp_beats.push_back(b);
        end
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input bit hdr);
        bit done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            in_if.tdata   = d;
            in_if.tkeep   = k;
            in_if.tlast   = l;
            in_if.tvalid  = 1'b1;
            out_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (in_if.tready) begin
                done = 1;
                model_accept(d, k, l, hdr);
            end
        end
        if (!done) check("beat_accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_if.tvalid  = 1'b0;
            in_if.tlast   = 1'b0;
            out_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic send_pkt(input logic [31:0] seq, input int n_pay);
        logic [DW-1:0] h;
        h = rand_data();
        h[31:0] = seq;
        drive_beat(h, KW'($urandom), n_pay == 0, 1);
        for (int i = 0; i < n_pay; i++)
            drive_beat(rand_data(), KW'($urandom), i == n_pay - 1, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        out_if.tready = 1'b1;
        exp_beats.delete();
        p_exp = '0; p_synced = 0; p_err = 0; p_errcnt = '0; p_empty = '0; p_pkt = '0;
        beats_out = 0; tlast_seen = 0; err_pulses = 0;
        #1;
        check("rst_out_tvalid", out_if.tvalid, 0);
        check("rst_in_tready", in_if.tready, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Commit the model's view at each edge, mirroring when the DUT's registers change.
    initial forever begin
        @(posedge clk);
        m_err    = p_err;
        m_errcnt = p_errcnt;
        m_empty  = p_empty;
        m_pkt    = p_pkt;
        p_err    = 0;
    end

    // Per-cycle compare of every DUT output against the model.
    initial begin
        beat_t b;
        bit    held_v = 0;
        beat_t held;
        forever begin
            @(negedge clk);
            #2;
            if (!resetn) begin
                check("rst_flags", {in_if.tready, out_if.tvalid, out_if.tlast, seq_err}, 0);
                check("rst_tdata", out_if.tdata, 0);
                check("rst_tkeep", out_if.tkeep, 0);
                check("rst_counts", {err_cnt, pkt_cnt, empty_cnt}, 0);
                held_v = 0;
            end else begin
                check("seq_err", seq_err, m_err);
                check("seq_err_cnt", err_cnt, m_errcnt);
                check("pkt_cnt", pkt_cnt, m_pkt);
                check("empty_cnt", empty_cnt, m_empty);
                if (seq_err) err_pulses++;
                if (held_v) begin
                    check("hold_tvalid", out_if.tvalid, 1);
                    check("hold_tdata", out_if.tdata, held.data);
                    check("hold_tkeep", out_if.tkeep, held.keep);
                    check("hold_tlast", out_if.tlast, held.last);
                end
                if (out_if.tvalid && out_if.tready) begin
                    if (exp_beats.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        b = exp_beats.pop_front();
                        check("out_tdata", out_if.tdata, b.data);
                        check("out_tkeep", out_if.tkeep, b.keep);
                        check("out_tlast", out_if.tlast, b.last);
                    end
                    beats_out++;
                    if (out_if.tlast) tlast_seen++;
                end
                held_v    = out_if.tvalid && !out_if.tready;
                held.data = out_if.tdata;
                held.keep = out_if.tkeep;
                held.last = out_if.tlast;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tkeep = '0; in_if.tlast = 1'b0;
        out_if.tready = 1'b1;

        // Back-to-back packets with an always-ready sink.
        apply_reset();
        send_pkt(32'd5, 3); send_pkt(32'd6, 3); send_pkt(32'd7, 3);
        idle(5); #3;
        check("s1_pkt_cnt", pkt_cnt, 3);
        check("s1_err_cnt", err_cnt, 0);
        check("s1_beats", beats_out, 9);
        check("s1_tlasts", tlast_seen, 3);

        // One gap in the sequence.
        apply_reset();
        send_pkt(32'd0, 1); send_pkt(32'd2, 1); send_pkt(32'd3, 1);
        idle(5); #3;
        check("s2_err_cnt", err_cnt, 1);
        check("s2_err_pulses", err_pulses, 1);

        // Sequence number wrap.
        apply_reset();
        send_pkt(32'hFFFF_FFFF, 1); send_pkt(32'd0, 1);
        idle(4); #3;
        check("s3_wrap_ok", err_cnt, 0);
        apply_reset();
        send_pkt(32'hFFFF_FFFF, 1); send_pkt(32'd1, 1);
        idle(4); #3;
        check("s3_wrap_bad", err_cnt, 1);

        // Header-only packet followed by a normal packet.
        apply_reset();
        send_pkt(32'd10, 0);
        idle(3); #3;
        check("s4_no_beat", beats_out, 0);
        check("s4_empty_cnt", empty_cnt, 1);
        send_pkt(32'd11, 2);
        idle(4); #3;
        check("s4_beats", beats_out, 2);
        check("s4_pkt_cnt", pkt_cnt, 2);
        check("s4_err_cnt", err_cnt, 0);

        // Backpressure soak with mixed lengths and occasional sequence gaps.
        apply_reset();
        rand_ready = 1;
        for (int i = 0; i < 100; i++)
            send_pkt(32'd100 + 32'(i) + ((i % 17 == 5) ? 32'd1 : 32'd0), $urandom_range(0, 4));
        rand_ready = 0;
        idle(10); #3;
        check("s5_drained", exp_beats.size(), 0);
        check("s5_pkt_cnt", pkt_cnt, 100);

        // Reset in the middle of a payload.
        apply_reset();
        send_pkt(32'd50, 0 + 0);
        apply_reset();
        drive_beat({96'd0, 32'd60}, '1, 1'b0, 1);
        drive_beat(rand_data(), '1, 1'b0, 0);
        drive_beat(rand_data(), '1, 1'b0, 0);
        apply_reset();
        send_pkt(32'd12345, 2);
        idle(4); #3;
        check("s6_err_cnt", err_cnt, 0);
        check("s6_pkt_cnt", pkt_cnt, 1);
        check("s6_beats", beats_out, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_header_checker.md
COUNTER_HEADER_CHECKER -- requirements
Module: counter_header_checker

Interface
REQ-001 Parameter DW, default 512, AXI-Stream data width in bits; legal values are multiples of 64.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 AXIS_IN_TDATA  input  DW  packet beat; first beat of each packet is the counter header.
REQ-005 AXIS_IN_TVALID / AXIS_IN_TREADY  input / output  1 each  input handshake.
REQ-006 AXIS_IN_TKEEP  input  DW/8  byte enables.
REQ-007 AXIS_IN_TLAST  input  1  last beat of packet.
REQ-008 AXIS_OUT_TDATA  output  DW  payload beat with the header removed.
REQ-009 AXIS_OUT_TVALID / AXIS_OUT_TREADY  output / input  1 each  output handshake.
REQ-010 AXIS_OUT_TKEEP  output  DW/8  byte enables.
REQ-011 AXIS_OUT_TLAST  output  1  last payload beat.
REQ-012 SEQ_ERR  output  1  one-cycle pulse on a sequence mismatch.
REQ-013 SEQ_ERR_CNT  output  16  saturating mismatch count.
REQ-014 PKT_CNT  output  32  wrapping count of accepted headers.
REQ-015 EMPTY_CNT  output  16  saturating count of header-only packets.

Function
REQ-016 Header format: TDATA[31:0] is the sequence number; the other header bits are ignored.
REQ-017 FSM states: HDR (waiting for a header beat) and PAY (forwarding payload beats).
REQ-018 In HDR, AXIS_IN_TREADY is 1 regardless of the output state.
REQ-019 In HDR, an accepted beat is consumed and is never forwarded.
REQ-020 HDR transitions to PAY on an accepted header with TLAST=0.
REQ-021 HDR stays in HDR on an accepted header with TLAST=1; such a packet is header-only and increments EMPTY_CNT (saturating at 16'hFFFF).
REQ-022 In PAY, AXIS_IN_TREADY = !AXIS_OUT_TVALID || AXIS_OUT_TREADY.
REQ-023 In PAY, an accepted beat loads TDATA, TKEEP and TLAST unchanged into the output register and sets AXIS_OUT_TVALID on the next cycle; latency is 1 cycle.
REQ-024 PAY transitions to HDR on acceptance of the beat with TLAST=1.
REQ-025 AXIS_OUT_TVALID clears after an output handshake unless a new beat is loaded in the same cycle.
REQ-026 Full throughput: one beat per cycle in PAY while AXIS_OUT_TREADY=1.
REQ-027 Output data is held stable while AXIS_OUT_TVALID=1 and AXIS_OUT_TREADY=0.
REQ-028 Sequence tracking uses a 32-bit register EXP and a flag SYNCED.
REQ-029 On any accepted header, EXP is set to seq+1 (modulo 2^32; 32'hFFFFFFFF wraps to 0).
REQ-030 On any accepted header, SYNCED is set to 1.
REQ-031 On any accepted header, PKT_CNT increments, wrapping from 32'hFFFFFFFF to 0.
REQ-032 When SYNCED=1 and seq!=EXP on an accepted header, SEQ_ERR pulses high for exactly the next cycle.
REQ-033 When SYNCED=1 and seq!=EXP on an accepted header, SEQ_ERR_CNT increments, saturating at 16'hFFFF.
REQ-034 The first header after reset (SYNCED=0) never flags an error.
REQ-035 A header beat accepted while the previous packet's last payload beat is still held in the output register does not disturb that beat.
REQ-036 TKEEP on the header beat is ignored.

Reset
REQ-037 While resetn=0: FSM=HDR and SYNCED=0.
REQ-038 While resetn=0: EXP=0, PKT_CNT=0, SEQ_ERR_CNT=0, EMPTY_CNT=0, SEQ_ERR=0.
REQ-039 While resetn=0: AXIS_OUT_TVALID=0, AXIS_OUT_TDATA=0, AXIS_OUT_TKEEP=0, AXIS_OUT_TLAST=0, AXIS_IN_TREADY=0.
REQ-040 Reset asserted mid-packet discards the packet in progress and any held output beat.
REQ-041 After reset, the next input beat is treated as a header.

Verification
REQ-042 Scenario 1: packets with seq 5, 6, 7, each 3 payload beats, AXIS_OUT_TREADY=1 -> 9 output beats, TLAST on beats 3, 6 and 9, PKT_CNT=3, SEQ_ERR_CNT=0.
REQ-043 Scenario 2: seq 0, then 2, then 3 -> one SEQ_ERR pulse on the header with seq=2, SEQ_ERR_CNT=1, no error on seq=3.
REQ-044 Scenario 3: seq 32'hFFFFFFFF then 0 -> no error; seq 32'hFFFFFFFF then 1 -> SEQ_ERR_CNT=1.
REQ-045 Scenario 4: header-only packet (TLAST on the header beat) -> no output beat, EMPTY_CNT=1, next beat parsed as a header.
REQ-046 Scenario 5: random AXIS_OUT_TREADY toggling over 100 packets -> output stream equals input minus headers, with no loss or duplication.
REQ-047 Scenario 6: resetn pulsed low mid-payload -> all outputs return to reset values; the next packet with any seq raises no error.
